// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and oversampling constants for uart_rx
package uart_pkg;

  localparam int OVS = 16;
  localparam int MID = 7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with parameterized reset value
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x-oversampled UART receiver; optional even parity under UART_RX_PARITY_EN
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            parity_err
);

  import uart_pkg::*;

  // s must reach both the mid-bit/full-bit points and SB_TICK-1 without wrapping
  localparam int SW = $clog2((SB_TICK > OVS) ? SB_TICK : OVS);
  localparam int NW = $clog2(DBIT);

  logic            w_rxs;
  state_t          r_state, w_state_nxt;
  logic [SW-1:0]   r_s, w_s_nxt;
  logic [NW-1:0]   r_n, w_n_nxt;
  logic [DBIT-1:0] r_b, w_b_nxt;
  logic [DBIT-1:0] r_dout, w_dout_nxt;
  logic            r_done, w_done_nxt;
  logic            r_ferr, w_ferr_nxt;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .i_d    (rx),
    .o_q    (w_rxs)
  );

`ifdef UART_RX_PARITY_EN
  logic r_p, w_p_nxt;
  logic r_perr, w_perr_nxt;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_dout  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_p     <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_n     <= w_n_nxt;
      r_b     <= w_b_nxt;
      r_dout  <= w_dout_nxt;
      r_done  <= w_done_nxt;
      r_ferr  <= w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
      r_p     <= w_p_nxt;
      r_perr  <= w_perr_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_n_nxt     = r_n;
    w_b_nxt     = r_b;
    w_dout_nxt  = r_dout;
    w_done_nxt  = 1'b0;
    w_ferr_nxt  = r_ferr;
`ifdef UART_RX_PARITY_EN
    w_p_nxt     = r_p;
    w_perr_nxt  = r_perr;
`endif
    case (r_state)
      IDLE: begin
        if (!w_rxs) begin
          w_state_nxt = START;
          w_s_nxt     = '0;
        end
      end
      START: begin
        // a start bit still low at its midpoint is real; otherwise treat it as a glitch
        if (s_tick) begin
          if (r_s == SW'(MID)) begin
            if (!w_rxs) begin
              w_state_nxt = DATA;
              w_s_nxt     = '0;
              w_n_nxt     = '0;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (r_s == SW'(OVS - 1)) begin
            w_s_nxt = '0;
            w_b_nxt = {w_rxs, r_b[DBIT-1:1]};
            if (r_n == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
              w_state_nxt = PARITY;
`else
              w_state_nxt = STOP;
`endif
            end else begin
              w_n_nxt = r_n + 1'b1;
            end
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (r_s == SW'(OVS - 1)) begin
            w_p_nxt     = w_rxs;
            w_s_nxt     = '0;
            w_state_nxt = STOP;
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (r_s == SW'(SB_TICK - 1)) begin
            w_state_nxt = IDLE;
            w_dout_nxt  = r_b;
            w_done_nxt  = 1'b1;
            w_ferr_nxt  = ~w_rxs;
`ifdef UART_RX_PARITY_EN
            w_perr_nxt  = ^{r_b, r_p};
`endif
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign dout         = r_dout;
  assign rx_done_tick = r_done;
  assign frame_err    = r_ferr;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = r_perr;
`else
  assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;

  localparam int DBIT    = 8;
  localparam int SB_TICK = 16;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            s_tick = 1'b0;
  logic            rx = 1'b1;
  logic [DBIT-1:0] dout;
  logic            rx_done_tick;
  logic            frame_err;
  logic            parity_err;

  int n_pass  = 0;
  int n_total = 0;
  int tick_div = 4;
  int tick_cnt = 0;

  logic [7:0] q_dout[$];
  logic       q_ferr[$];
  logic       q_perr[$];

  uart_rx #(.DBIT(DBIT), .SB_TICK(SB_TICK)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .s_tick      (s_tick),
    .rx          (rx),
    .dout        (dout),
    .rx_done_tick(rx_done_tick),
    .frame_err   (frame_err),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tick_cnt >= tick_div - 1) begin
      tick_cnt = 0;
      s_tick   = 1'b1;
    end else begin
      tick_cnt = tick_cnt + 1;
      s_tick   = 1'b0;
    end
  end

  // every cycle the pulse is high records an entry, so a stretched pulse shows up as an extra frame
  always @(negedge clk) begin
    if (rx_done_tick === 1'b1) begin
      q_dout.push_back(dout);
      q_ferr.push_back(frame_err);
      q_perr.push_back(parity_err);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic send_bit(input logic level, input int ticks);
    rx = level;
    repeat (ticks * tick_div) @(negedge clk);
  endtask

  task automatic idle_bits(input int bits);
    send_bit(1'b1, 16 * bits);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par,
                            input logic stop_lvl, input int stop_ticks);
    send_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) send_bit(data[i], 16);
`ifdef UART_RX_PARITY_EN
    send_bit(par, 16);
`endif
    send_bit(stop_lvl, stop_ticks);
    rx = 1'b1;
  endtask

  task automatic clear_q();
    q_dout.delete();
    q_ferr.delete();
    q_perr.delete();
  endtask

  task automatic check_frame(input string tag, input int idx, input logic [7:0] exp_d,
                             input logic exp_f, input logic exp_p);
    check({tag, "_dout"}, (idx < q_dout.size()) ? {24'h0, q_dout[idx]} : 32'hxxxxxxxx, {24'h0, exp_d});
    check({tag, "_ferr"}, (idx < q_ferr.size()) ? {31'h0, q_ferr[idx]} : 32'hxxxxxxxx, {31'h0, exp_f});
    check({tag, "_perr"}, (idx < q_perr.size()) ? {31'h0, q_perr[idx]} : 32'hxxxxxxxx, {31'h0, exp_p});
  endtask

  initial begin
    reset_n = 1'b0;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_dout", {24'h0, dout}, 32'h0);
    check("rst_done", {31'h0, rx_done_tick}, 32'h0);
    check("rst_ferr", {31'h0, frame_err}, 32'h0);
    check("rst_perr", {31'h0, parity_err}, 32'h0);
    reset_n = 1'b1;
    idle_bits(2);

    clear_q();
    send_frame(8'h55, ^8'h55, 1'b1, 16);
    idle_bits(2);
    check("f55_count", q_dout.size(), 1);
    check_frame("f55", 0, 8'h55, 1'b0, 1'b0);

    // stop held low only past its sampling point so the line is idle again before the next frame
    clear_q();
    send_frame(8'hA3, ^8'hA3, 1'b0, 10);
    idle_bits(2);
    send_frame(8'h3C, ^8'h3C, 1'b1, 16);
    idle_bits(2);
    check("ferr_count", q_dout.size(), 2);
    check_frame("fA3", 0, 8'hA3, 1'b1, 1'b0);
    check_frame("f3C", 1, 8'h3C, 1'b0, 1'b0);

    clear_q();
    send_bit(1'b0, 4);
    idle_bits(3);
    check("glitch_count", q_dout.size(), 0);
    send_frame(8'h5A, ^8'h5A, 1'b1, 16);
    idle_bits(2);
    check("post_glitch_count", q_dout.size(), 1);
    check_frame("f5A", 0, 8'h5A, 1'b0, 1'b0);

    clear_q();
    send_frame(8'h00, ^8'h00, 1'b1, 16);
    send_frame(8'hFF, ^8'hFF, 1'b1, 16);
    idle_bits(2);
    check("b2b_count", q_dout.size(), 2);
    check_frame("f00", 0, 8'h00, 1'b0, 1'b0);
    check_frame("fFF", 1, 8'hFF, 1'b0, 1'b0);

    // abort 0x0F during data bit 3 (a 1) so the line is high when reset releases
    clear_q();
    send_bit(1'b0, 16);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 16);
    send_bit(1'b1, 8);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_dout", {24'h0, dout}, 32'h0);
    check("midrst_done", {31'h0, rx_done_tick}, 32'h0);
    check("midrst_ferr", {31'h0, frame_err}, 32'h0);
    reset_n = 1'b1;
    idle_bits(12);
    check("abort_count", q_dout.size(), 0);
    send_frame(8'h81, ^8'h81, 1'b1, 16);
    idle_bits(2);
    check("f81_count", q_dout.size(), 1);
    check_frame("f81", 0, 8'h81, 1'b0, 1'b0);

    tick_div = 1;
    idle_bits(1);
    clear_q();
    send_frame(8'hC6, ^8'hC6, 1'b1, 16);
    idle_bits(2);
    check("fast_count", q_dout.size(), 1);
    check_frame("fC6", 0, 8'hC6, 1'b0, 1'b0);
    tick_div = 4;
    idle_bits(1);

`ifdef UART_RX_PARITY_EN
    clear_q();
    send_frame(8'h07, 1'b1, 1'b1, 16);
    idle_bits(2);
    send_frame(8'h07, 1'b0, 1'b1, 16);
    idle_bits(2);
    check("par_count", q_dout.size(), 2);
    check_frame("par_good", 0, 8'h07, 1'b0, 1'b0);
    check_frame("par_bad", 1, 8'h07, 1'b0, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
